// File: rtl/sc_fifo_ext.sv
// sc_fifo_ext: single-clock FIFO with FWFT/registered read, occupancy flags,
// high-watermark tracking and sticky overflow/underflow error reporting.
module sc_fifo_ext #(
  parameter int DW   = 32,
  parameter int PTRW = 8,
  parameter int FWFT = 1,
  parameter int CW   = 8
)(
  input  logic            clk,
  input  logic            reset_n,
  input  logic [DW-1:0]   datain,
  input  logic            wr_op,
  input  logic            rd_op,
  input  logic            flush,
  input  logic            clr_err,
  input  logic [PTRW:0]   afull_thrs,
  input  logic [PTRW:0]   aempty_thrs,
  output logic [DW-1:0]   dataout,
  output logic            rd_vld,
  output logic            empty,
  output logic            full,
  output logic            afull,
  output logic            aempty,
  output logic [PTRW:0]   entry_used,
  output logic [PTRW:0]   max_used,
  output logic            wr_full_err,
  output logic            rd_empty_err,
  output logic [CW-1:0]   ovf_cnt,
  output logic [CW-1:0]   udf_cnt
);
  localparam logic [PTRW:0] DEPTH = {1'b1, {PTRW{1'b0}}};

  logic [DW-1:0]   r_mem [2**PTRW];
  logic [PTRW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTRW:0]   r_used, r_max_used, w_used_nxt;
  logic            r_wr_err, r_rd_err;
  logic [CW-1:0]   r_ovf_cnt, r_udf_cnt;
  logic            w_wr_acc, w_rd_acc, w_ovf, w_udf;

  assign empty  = r_used == '0;
  assign full   = r_used == DEPTH;
  assign afull  = r_used >= afull_thrs;
  assign aempty = r_used <= aempty_thrs;
  assign entry_used   = r_used;
  assign max_used     = r_max_used;
  assign wr_full_err  = r_wr_err;
  assign rd_empty_err = r_rd_err;
  assign ovf_cnt      = r_ovf_cnt;
  assign udf_cnt      = r_udf_cnt;

  // flush masks both requests so nothing is accepted or flagged as an error
  assign w_rd_acc = rd_op & ~empty & ~flush;
  assign w_wr_acc = wr_op & (~full | w_rd_acc) & ~flush;
  assign w_ovf    = wr_op & ~flush & ~w_wr_acc;
  assign w_udf    = rd_op & ~flush & empty;
  assign w_used_nxt = flush ? '0 :
    r_used + {{PTRW{1'b0}}, w_wr_acc} - {{PTRW{1'b0}}, w_rd_acc};

  function automatic logic [CW-1:0] f_cnt(input logic [CW-1:0] c, input logic clr, input logic ev);
    return clr ? CW'(ev) : (ev && c != '1) ? c + CW'(1) : c;
  endfunction

  always_ff @(posedge clk)
    if (w_wr_acc) r_mem[r_wr_ptr] <= datain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_used     <= '0;
      r_max_used <= '0;
      r_wr_err   <= 1'b0;
      r_rd_err   <= 1'b0;
      r_ovf_cnt  <= '0;
      r_udf_cnt  <= '0;
    end else begin
      r_wr_ptr   <= flush ? '0 : r_wr_ptr + PTRW'(w_wr_acc);
      r_rd_ptr   <= flush ? '0 : r_rd_ptr + PTRW'(w_rd_acc);
      r_used     <= w_used_nxt;
      r_max_used <= w_used_nxt > r_max_used ? w_used_nxt : r_max_used;
      r_wr_err   <= w_ovf | (r_wr_err & ~clr_err);
      r_rd_err   <= w_udf | (r_rd_err & ~clr_err);
      r_ovf_cnt  <= f_cnt(r_ovf_cnt, clr_err, w_ovf);
      r_udf_cnt  <= f_cnt(r_udf_cnt, clr_err, w_udf);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign dataout = empty ? '0 : r_mem[r_rd_ptr];
      assign rd_vld  = ~empty;
    end else begin : g_reg
      logic [DW-1:0] r_dout;
      logic          r_rd_vld;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_dout   <= '0;
          r_rd_vld <= 1'b0;
        end else begin
          r_dout   <= w_rd_acc ? r_mem[r_rd_ptr] : r_dout;
          r_rd_vld <= w_rd_acc;
        end
      end
      assign dataout = r_dout;
      assign rd_vld  = r_rd_vld;
    end
  endgenerate
endmodule

// File: tb/tb_sc_fifo_ext.sv
// tb_sc_fifo_ext: table-driven check of a 4-deep FWFT FIFO with a queue
// scoreboard for read data, plus hand sequences for reset, flush and FWFT=0.
module tb_sc_fifo_ext;
  localparam int DW = 8, PW = 2, CW = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] din1 = '0, dout1, din0 = '0, dout0;
  logic wr1 = 0, rd1 = 0, fl1 = 0, clr1 = 0, wr0 = 0, rd0 = 0;
  logic [PW:0] aft = 3'd3, aet = 3'd1, used1, max1, used0, max0;
  logic vld1, emp1, ful1, af1, ae1, we1, re1;
  logic vld0, emp0, ful0, af0, ae0, we0, re0;
  logic [CW-1:0] ovf1, udf1, ovf0, udf0;

  sc_fifo_ext #(.DW(DW), .PTRW(PW), .FWFT(1), .CW(CW)) dut1 (
    .clk(clk), .reset_n(rst_n), .datain(din1), .wr_op(wr1), .rd_op(rd1), .flush(fl1),
    .clr_err(clr1), .afull_thrs(aft), .aempty_thrs(aet), .dataout(dout1), .rd_vld(vld1),
    .empty(emp1), .full(ful1), .afull(af1), .aempty(ae1), .entry_used(used1), .max_used(max1),
    .wr_full_err(we1), .rd_empty_err(re1), .ovf_cnt(ovf1), .udf_cnt(udf1));

  sc_fifo_ext #(.DW(DW), .PTRW(PW), .FWFT(0), .CW(CW)) dut0 (
    .clk(clk), .reset_n(rst_n), .datain(din0), .wr_op(wr0), .rd_op(rd0), .flush(1'b0),
    .clr_err(1'b0), .afull_thrs(aft), .aempty_thrs(aet), .dataout(dout0), .rd_vld(vld0),
    .empty(emp0), .full(ful0), .afull(af0), .aempty(ae0), .entry_used(used0), .max_used(max0),
    .wr_full_err(we0), .rd_empty_err(re0), .ovf_cnt(ovf0), .udf_cnt(udf0));

  int errs = 0, checks = 0;
  logic [DW-1:0] q1[$], q0[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step1(input logic w, input logic r, input logic f, input logic c, input logic [DW-1:0] d);
    logic ra, wa;
    @(negedge clk);
    wr1 = w; rd1 = r; fl1 = f; clr1 = c; din1 = d;
    if (f) q1.delete();
    else begin
      ra = r && q1.size() > 0;
      wa = w && (q1.size() < 4 || ra);
      if (ra) void'(q1.pop_front());
      if (wa) q1.push_back(d);
    end
    @(posedge clk); #1;
    wr1 = 0; rd1 = 0; fl1 = 0; clr1 = 0;
  endtask

  task automatic step0(input logic w, input logic r, input logic [DW-1:0] d);
    @(negedge clk);
    wr0 = w; rd0 = r; din0 = d;
    if (w) q0.push_back(d);
    @(posedge clk); #1;
    wr0 = 0; rd0 = 0;
  endtask

  task automatic chk_flags(input string nm, input int u);
    chk({nm, " used"}, 32'(used1), u);
    chk({nm, " empty"}, 32'(emp1), 32'(u == 0));
    chk({nm, " full"}, 32'(ful1), 32'(u == 4));
    chk({nm, " afull"}, 32'(af1), 32'(u >= 3));
    chk({nm, " aempty"}, 32'(ae1), 32'(u <= 1));
    chk({nm, " dataout"}, 32'(dout1), q1.size() > 0 ? 32'(q1[0]) : 32'h0);
    chk({nm, " rd_vld"}, 32'(vld1), 32'(q1.size() > 0));
  endtask

  typedef struct {int wr, rd, fl, clr, din, used, werr, rerr, ovf, udf, maxu;} vec_t;
  vec_t tbl[24];

  initial begin
    tbl[0]  = '{1,0,0,0,'hA1, 1,0,0,0,0,1};
    tbl[1]  = '{1,0,0,0,'hB2, 2,0,0,0,0,2};
    tbl[2]  = '{1,0,0,0,'hC3, 3,0,0,0,0,3};
    tbl[3]  = '{1,0,0,0,'hD4, 4,0,0,0,0,4};
    tbl[4]  = '{1,0,0,0,'hE5, 4,1,0,1,0,4};
    tbl[5]  = '{1,1,0,0,'hF6, 4,1,0,1,0,4};
    tbl[6]  = '{0,1,0,0,'h00, 3,1,0,1,0,4};
    tbl[7]  = '{0,1,0,0,'h00, 2,1,0,1,0,4};
    tbl[8]  = '{0,1,0,0,'h00, 1,1,0,1,0,4};
    tbl[9]  = '{0,1,0,0,'h00, 0,1,0,1,0,4};
    tbl[10] = '{1,1,0,0,'h55, 1,1,1,1,1,4};
    tbl[11] = '{0,0,0,1,'h00, 1,0,0,0,0,4};
    tbl[12] = '{0,1,0,0,'h00, 0,0,0,0,0,4};
    tbl[13] = '{0,1,0,0,'h00, 0,0,1,0,1,4};
    tbl[14] = '{0,1,0,0,'h00, 0,0,1,0,2,4};
    tbl[15] = '{0,1,0,0,'h00, 0,0,1,0,3,4};
    tbl[16] = '{0,1,0,0,'h00, 0,0,1,0,3,4};
    tbl[17] = '{0,1,0,1,'h00, 0,0,1,0,1,4};
    tbl[18] = '{1,0,0,0,'h31, 1,0,1,0,1,4};
    tbl[19] = '{1,0,0,0,'h32, 2,0,1,0,1,4};
    tbl[20] = '{1,0,0,0,'h33, 3,0,1,0,1,4};
    tbl[21] = '{1,0,1,0,'h34, 0,0,1,0,1,4};
    tbl[22] = '{0,1,1,0,'h00, 0,0,1,0,1,4};
    tbl[23] = '{1,0,0,0,'h41, 1,0,1,0,1,4};

    #2;
    chk_flags("reset", 0);
    chk("reset max", 32'(max1), 0);
    chk("reset ovf", 32'(ovf1), 0);
    chk("reset dout0", 32'(dout0), 0);
    chk("reset vld0", 32'(vld0), 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      string nm;
      nm = $sformatf("v%0d", i);
      step1(tbl[i].wr != 0, tbl[i].rd != 0, tbl[i].fl != 0, tbl[i].clr != 0, DW'(tbl[i].din));
      chk_flags(nm, tbl[i].used);
      chk({nm, " werr"}, 32'(we1), tbl[i].werr);
      chk({nm, " rerr"}, 32'(re1), tbl[i].rerr);
      chk({nm, " ovf"}, 32'(ovf1), tbl[i].ovf);
      chk({nm, " udf"}, 32'(udf1), tbl[i].udf);
      chk({nm, " max"}, 32'(max1), tbl[i].maxu);
    end

    // asynchronous reset mid-cycle while filling
    @(negedge clk); wr1 = 1; din1 = 8'h42;
    @(posedge clk); #2 rst_n = 1'b0; wr1 = 0;
    #1 q1.delete();
    chk_flags("async rst", 0);
    chk("async rst max", 32'(max1), 0);
    chk("async rst errs", {re1, we1, ovf1, udf1}, 0);
    @(negedge clk); rst_n = 1'b1;

    step1(1, 0, 0, 0, 8'h61);
    step1(1, 0, 0, 0, 8'h62);
    step1(1, 0, 0, 0, 8'h63);
    chk_flags("fill3", 3);
    step1(1, 0, 1, 0, 8'h64);
    chk_flags("flush", 0);
    chk("flush max", 32'(max1), 3);
    chk("flush errs", {re1, we1, ovf1, udf1}, 0);
    step1(1, 0, 0, 0, 8'h65);
    chk_flags("post flush wr", 1);

    // registered-read instance
    step0(1, 0, 8'h11);
    chk("r0 idle vld", 32'(vld0), 0);
    chk("r0 idle dout", 32'(dout0), 0);
    step0(1, 0, 8'h22);
    for (int k = 0; k < 2; k++) begin
      step0(0, 1, 8'h00);
      chk($sformatf("r0 rd%0d vld", k), 32'(vld0), 1);
      chk($sformatf("r0 rd%0d dout", k), 32'(dout0), 32'(q0.pop_front()));
    end
    step0(0, 0, 8'h00);
    chk("r0 hold vld", 32'(vld0), 0);
    chk("r0 hold dout", 32'(dout0), 32'h22);
    step0(0, 1, 8'h00);
    chk("r0 udf vld", 32'(vld0), 0);
    chk("r0 udf cnt", 32'(udf0), 1);
    chk("r0 udf flag", 32'(re0), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
